conv55_window_feeder: RTL and testbench
=======================================

CONV55_WINDOW_FEEDER -- requirements
Module: conv55_window_feeder

Interface
REQ-001 Parameter: IMG_W, default 32, feature-map width in pixels (>=5).
REQ-002 Parameter: IMG_H, default 32, feature-map height in pixels (>=5).
REQ-003 Port: clk  input  1  single clock; all state updates on rising edge.
REQ-004 Port: rst_n  input  1  reset, synchronous, active-low.
REQ-005 Port: pix_in  input  8  raster-order pixel, row-major, unsigned.
REQ-006 Port: pix_valid  input  1  pix_in valid.
REQ-007 Port: pix_ready  output  1  feeder accepts pix_in this cycle.
REQ-008 Port: win_data  output  200  5x5 window; byte k = win_data[8k+7:8k] maps to in_data_k of the 5x5 convolution datapath.
REQ-009 Port: win_valid  output  1  win_data holds a complete window.
REQ-010 Port: win_ready  input  1  consumer takes the window this cycle.

Function
REQ-011 A pixel transfers when pix_valid and pix_ready are both high on a rising edge; a window transfers when win_valid and win_ready are both high.
REQ-012 pix_ready SHALL equal (!win_valid || win_ready), combinationally; no other input gating.
REQ-013 Column counter col (0..IMG_W-1) and row counter row (0..IMG_H-1) SHALL advance only on pixel transfer; col wraps to 0 and increments row; row wraps to 0 after the last pixel of a frame.
REQ-014 Four line buffers of IMG_W x 8 bits SHALL hold the previous four rows; a 5x5 register array SHALL shift one column left per accepted pixel.
REQ-015 Byte k = 5r+c of the window SHALL be pixel (row-4+r, col-4+c), where (row, col) is the completing pixel; byte 0 = top-left, byte 24 = newest pixel.
REQ-016 A window SHALL be produced only when the completing pixel has row>=4 and col>=4; (IMG_W-4)*(IMG_H-4) windows per frame; no window spans a row or frame boundary.
REQ-017 Latency: win_valid SHALL rise on the edge that accepts the completing pixel (window registered, visible the next cycle).
REQ-018 win_data and win_valid SHALL be held stable while win_valid=1 and win_ready=0.
REQ-019 On window transfer with no new completing pixel in the same cycle, win_valid SHALL clear; with simultaneous transfer and completing pixel, win_valid SHALL stay 1 and win_data update.
REQ-020 State machine: FILL (row<4 or col<4; no window), STREAM (window-producing positions), with transition FILL->STREAM on the first completing pixel of each row at row>=4 and STREAM->FILL on col wrap; frame wrap returns to FILL with row=0.
REQ-021 Line-buffer contents from a previous frame SHALL never appear in a window of the next frame (guaranteed by REQ-016 ordering).

Reset
REQ-022 While rst_n=0 at a rising edge: win_valid=0, col=0, row=0, state=FILL, 5x5 array cleared to 0, win_data=0.
REQ-023 pix_ready SHALL be 1 the first cycle after reset; line-buffer RAM contents need not be cleared.
REQ-024 Reset mid-frame SHALL discard the partial frame; the next accepted pixel is (0,0).

Configuration
REQ-025 Macro CONV55_FEEDER_FRAME_DONE_EN: when defined, add output port frame_done (1 bit, reset 0) pulsing high for exactly one cycle after the transfer of the last window of a frame; when undefined, the port and its logic are absent and all other behaviour is identical.

Verification
REQ-026 IMG_W=IMG_H=32, pixel = (row*32+col) mod 256, win_ready=1 -> first win_valid after 133rd pixel; byte0=0, byte4=4, byte20=128, byte24=132.
REQ-027 Full frame, win_ready=1 -> exactly 784 windows; last window byte24=255 (1023 mod 256), byte0=(27*32+27) mod 256=123.
REQ-028 win_ready held 0 for 10 cycles while win_valid=1 -> pix_ready=0, win_data unchanged; release -> window taken, stream resumes with no pixel lost.
REQ-029 rst_n low one cycle after 50 pixels -> win_valid=0; restart frame yields first window after 133 further pixels with byte0=0.
REQ-030 Two back-to-back frames, random pix_valid/win_ready -> 1568 windows, all matching software model; with CONV55_FEEDER_FRAME_DONE_EN, exactly two one-cycle frame_done pulses.

Source files
------------

// File: rtl/conv55_window_feeder.sv
// conv55_window_feeder: turns a raster pixel stream into 5x5 sliding windows using four line buffers.
// Optional feature macro CONV55_FEEDER_FRAME_DONE_EN adds a frame_done pulse after a frame's last window.
module conv55_window_feeder #(
  parameter int IMG_W = 32,
  parameter int IMG_H = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [7:0]   pix_in,
  input  logic         pix_valid,
  output logic         pix_ready,
  output logic [199:0] win_data,
  output logic         win_valid,
  input  logic         win_ready,
  output logic         o_dbg_state
`ifdef CONV55_FEEDER_FRAME_DONE_EN
  ,
  output logic         frame_done
`endif
);
  localparam int CW = $clog2(IMG_W);
  localparam int RW = $clog2(IMG_H);

  typedef enum logic {S_FILL = 1'b0, S_STREAM = 1'b1} state_t;

  // Handshake: a beat moves on a rising edge where its valid and ready are both high; a
  // producer never drops valid or changes data until that happens, ready may toggle freely.
  logic [CW-1:0] r_col;
  logic [RW-1:0] r_row;
  state_t        r_state;
  state_t        w_state_nxt;
  logic          r_win_valid;
  logic          w_win_valid_nxt;
  logic [7:0]    r_lb  [4][IMG_W];
  logic [7:0]    r_win [5][5];
  logic [7:0]    w_col_vec [5];
  logic          w_acc;
  logic          w_xfer;
  logic          w_complete;
  logic          w_col_last;
  logic          w_row_last;

  assign pix_ready   = !r_win_valid || win_ready;
  assign win_valid   = r_win_valid;
  assign o_dbg_state = r_state;
  assign w_acc       = pix_valid && pix_ready;
  assign w_xfer      = r_win_valid && win_ready;
  assign w_col_last  = (r_col == CW'(IMG_W - 1));
  assign w_row_last  = (r_row == RW'(IMG_H - 1));
  assign w_complete  = (r_row >= RW'(4)) && (r_col >= CW'(4));

  // New window column, oldest row first: lb[3] holds row-4, lb[0] holds row-1.
  always_comb begin
    w_col_vec[0] = r_lb[3][r_col];
    w_col_vec[1] = r_lb[2][r_col];
    w_col_vec[2] = r_lb[1][r_col];
    w_col_vec[3] = r_lb[0][r_col];
    w_col_vec[4] = pix_in;
  end

  always_ff @(posedge clk) begin
    if (w_acc) begin
      r_lb[3][r_col] <= r_lb[2][r_col];
      r_lb[2][r_col] <= r_lb[1][r_col];
      r_lb[1][r_col] <= r_lb[0][r_col];
      r_lb[0][r_col] <= pix_in;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int r = 0; r < 5; r++)
        for (int c = 0; c < 5; c++)
          r_win[r][c] <= '0;
    end else if (w_acc) begin
      for (int r = 0; r < 5; r++) begin
        for (int c = 0; c < 4; c++)
          r_win[r][c] <= r_win[r][c+1];
        r_win[r][4] <= w_col_vec[r];
      end
    end
  end

  always_comb begin
    win_data = '0;
    for (int r = 0; r < 5; r++)
      for (int c = 0; c < 5; c++)
        win_data[8*(5*r+c) +: 8] = r_win[r][c];
  end

  always_comb begin
    w_state_nxt     = r_state;
    w_win_valid_nxt = r_win_valid;
    if (w_xfer)
      w_win_valid_nxt = 1'b0;
    if (w_acc) begin
      if (w_complete)
        w_win_valid_nxt = 1'b1;
      if (w_col_last)
        w_state_nxt = S_FILL;
      else if (w_complete)
        w_state_nxt = S_STREAM;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_col       <= '0;
      r_row       <= '0;
      r_state     <= S_FILL;
      r_win_valid <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_win_valid <= w_win_valid_nxt;
      if (w_acc) begin
        if (w_col_last) begin
          r_col <= '0;
          r_row <= w_row_last ? '0 : r_row + RW'(1);
        end else begin
          r_col <= r_col + CW'(1);
        end
      end
    end
  end

`ifdef CONV55_FEEDER_FRAME_DONE_EN
  logic r_last_pend;
  logic r_frame_done;

  // r_last_pend marks that the window currently held is the final one of its frame.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_last_pend  <= 1'b0;
      r_frame_done <= 1'b0;
    end else begin
      r_frame_done <= w_xfer && r_last_pend;
      if (w_acc && w_complete)
        r_last_pend <= w_row_last && w_col_last;
      else if (w_xfer)
        r_last_pend <= 1'b0;
    end
  end

  assign frame_done = r_frame_done;
`endif

endmodule

// File: tb/tb_conv55_window_feeder.sv
// Bench for conv55_window_feeder: image-level reference model, per-cycle compare, directed scenarios.
module tb_conv55_window_feeder;
  localparam int W = 32;
  localparam int H = 32;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [7:0]   pix_in = '0;
  logic         pix_valid = 1'b0;
  logic         pix_ready;
  logic [199:0] win_data;
  logic         win_valid;
  logic         win_ready = 1'b1;
  logic         o_dbg_state;
`ifdef CONV55_FEEDER_FRAME_DONE_EN
  logic         frame_done;
`endif

  conv55_window_feeder #(.IMG_W(W), .IMG_H(H)) dut (
    .clk(clk), .rst_n(rst_n), .pix_in(pix_in), .pix_valid(pix_valid),
    .pix_ready(pix_ready), .win_data(win_data), .win_valid(win_valid),
    .win_ready(win_ready), .o_dbg_state(o_dbg_state)
`ifdef CONV55_FEEDER_FRAME_DONE_EN
    , .frame_done(frame_done)
`endif
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  function automatic void check(input string name, input logic [199:0] act, input logic [199:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endfunction

  // Reference model: the current frame as a 2-D image, windows cut out by coordinates.
  logic [7:0]   img [H][W];
  logic [199:0] exp_q [$];
  bit           last_q [$];
  int           m_row = 0;
  int           m_col = 0;
  logic         exp_valid = 1'b0;
  logic         exp_fd = 1'b0;
  int           win_cnt = 0;
  int           fd_cnt = 0;

  always @(negedge clk) begin
    logic         acc;
    logic         xfer;
    logic         nfd;
    logic [199:0] w;
    if (!rst_n) begin
      m_row = 0; m_col = 0; exp_valid = 1'b0; exp_fd = 1'b0;
      exp_q.delete(); last_q.delete();
    end else begin
      check("pix_ready", 200'(pix_ready), 200'(!exp_valid || win_ready));
      check("win_valid", 200'(win_valid), 200'(exp_valid));
`ifdef CONV55_FEEDER_FRAME_DONE_EN
      check("frame_done", 200'(frame_done), 200'(exp_fd));
      if (frame_done) fd_cnt++;
`endif
      if (exp_valid) begin
        if (exp_q.size() == 0) check("win_queue_empty", 200'(1), 200'(0));
        else check("win_data", win_data, exp_q[0]);
      end
      xfer = exp_valid && win_ready;
      acc  = pix_valid && (!exp_valid || win_ready);
      nfd  = 1'b0;
      if (xfer && exp_q.size() > 0) begin
        nfd = last_q[0];
        void'(exp_q.pop_front());
        void'(last_q.pop_front());
        win_cnt++;
      end
      if (acc) begin
        img[m_row][m_col] = pix_in;
        if (m_row >= 4 && m_col >= 4) begin
          w = '0;
          for (int r = 0; r < 5; r++)
            for (int c = 0; c < 5; c++)
              w[8*(5*r+c) +: 8] = img[m_row-4+r][m_col-4+c];
          exp_q.push_back(w);
          last_q.push_back(m_row == H-1 && m_col == W-1);
          exp_valid = 1'b1;
        end else if (xfer) begin
          exp_valid = 1'b0;
        end
        if (m_col == W-1) begin
          m_col = 0;
          m_row = (m_row == H-1) ? 0 : m_row + 1;
        end else begin
          m_col++;
        end
      end else if (xfer) begin
        exp_valid = 1'b0;
      end
      exp_fd = nfd;
    end
  end

  bit rand_ready = 1'b0;
  always @(posedge clk) begin
    #1;
    if (rand_ready) win_ready = 1'($urandom_range(0, 1));
  end

  task automatic send_px(input logic [7:0] v, input int gap);
    int guard;
    repeat (gap) begin @(posedge clk); #1; end
    pix_in = v;
    pix_valid = 1'b1;
    guard = 0;
    @(negedge clk);
    while (!pix_ready && guard < 200) begin
      guard++;
      @(negedge clk);
    end
    if (guard >= 200) begin
      tests++; fails++;
      $display("FAIL send_px_timeout: pix_ready stuck at 0, required 1 within 200 cycles");
    end
    @(posedge clk); #1;
    pix_valid = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    pix_valid = 1'b0;
    repeat (2) begin @(posedge clk); #1; end
    rst_n = 1'b1;
    check("rst_win_valid", 200'(win_valid), 200'(0));
    check("rst_pix_ready", 200'(pix_ready), 200'(1));
    check("rst_win_data", win_data, 200'(0));
    check("rst_state", 200'(o_dbg_state), 200'(0));
  endtask

  initial begin
    int first;
    int base;
    logic [199:0] snap;

    // Ramp frame with a 10-cycle consumer stall on the first window.
    do_reset();
    win_ready = 1'b1;
    base = win_cnt;
    first = 0;
    for (int i = 0; i < W*H; i++) begin
      send_px(8'(i), 0);
      if (win_valid && first == 0) begin
        first = i + 1;
        snap = win_data;
        check("first_win_pixel_count", 200'(first), 200'(133));
        check("first_byte0", 200'(snap[7:0]), 200'(0));
        check("first_byte4", 200'(snap[39:32]), 200'(4));
        check("first_byte20", 200'(snap[167:160]), 200'(128));
        check("first_byte24", 200'(snap[199:192]), 200'(132));
        check("state_stream", 200'(o_dbg_state), 200'(1));
        win_ready = 1'b0;
        pix_in = 8'(i + 1);
        pix_valid = 1'b1;
        repeat (10) begin
          @(negedge clk);
          check("stall_pix_ready", 200'(pix_ready), 200'(0));
          check("stall_win_valid", 200'(win_valid), 200'(1));
          check("stall_win_data", win_data, snap);
        end
        @(posedge clk); #1;
        win_ready = 1'b1;
      end
      if (i == W*H-1) begin
        check("last_win_valid", 200'(win_valid), 200'(1));
        check("last_byte24", 200'(win_data[199:192]), 200'(255));
        check("last_byte0", 200'(win_data[7:0]), 200'(123));
      end
    end
    repeat (3) begin @(posedge clk); #1; end
    check("frame_windows", 200'(win_cnt - base), 200'(784));

    // Mid-frame reset: partial frame of non-ramp values is discarded.
    do_reset();
    for (int i = 0; i < 50; i++) send_px(8'(i + 77), 0);
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    check("midrst_win_valid", 200'(win_valid), 200'(0));
    check("midrst_win_data", win_data, 200'(0));
    first = 0;
    for (int i = 0; i < 133; i++) begin
      send_px(8'(i), 0);
      if (win_valid && first == 0) begin
        first = i + 1;
        check("midrst_byte0", 200'(win_data[7:0]), 200'(0));
        check("midrst_byte24", 200'(win_data[199:192]), 200'(132));
      end
    end
    check("midrst_first_count", 200'(first), 200'(133));

    // Two back-to-back frames of random pixels with random gaps and back-pressure.
    do_reset();
    base = win_cnt;
    fd_cnt = 0;
    rand_ready = 1'b1;
    for (int f = 0; f < 2; f++)
      for (int i = 0; i < W*H; i++)
        send_px(8'($urandom_range(0, 255)), $urandom_range(0, 2));
    rand_ready = 1'b0;
    @(posedge clk); #2;
    win_ready = 1'b1;
    repeat (5) begin @(posedge clk); #1; end
    check("two_frame_windows", 200'(win_cnt - base), 200'(1568));
    check("queue_drained", 200'(exp_q.size()), 200'(0));
`ifdef CONV55_FEEDER_FRAME_DONE_EN
    check("frame_done_pulses", 200'(fd_cnt), 200'(2));
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
